// File: rtl/xor_cipher_ctrl.sv
// Sequencer/arbiter for a shared 4-bit XOR datapath: round-robin grant between
// an encrypt (ch0) and decrypt (ch1) requester, per-channel rolling key, valid/ready result.

module xor_cipher_chan #(
  parameter bit ROT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  input  logic [3:0] key,
  output logic [3:0] rkey
);
  logic [1:0] cnt;
  logic [1:0] amt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= 2'd0;
    else if (clr) cnt <= 2'd0;
    else if (inc) cnt <= cnt + 2'd1;
  end

  assign amt = ROT_EN ? cnt : 2'd0;

  always_comb begin
    rkey = key;
    case (amt)
      2'd1:    rkey = {key[2:0], key[3]};
      2'd2:    rkey = {key[1:0], key[3:2]};
      2'd3:    rkey = {key[0],   key[3:1]};
      default: rkey = key;
    endcase
  end
endmodule

module xor_cipher_ctrl #(
  parameter bit         ROT_EN    = 1'b1,
  parameter logic [3:0] KEY_RESET = 4'b0000
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       KeyLoad,
  input  logic [3:0] KeyIn,
  input  logic [1:0] Req,
  input  logic [3:0] Data0,
  input  logic [3:0] Data1,
  output logic [1:0] Gnt,
  output logic [3:0] XorWord,
  output logic [3:0] XorKey,
  input  logic [3:0] XorOut,
  output logic       OutValid,
  output logic [3:0] OutData,
  output logic       OutId,
  input  logic       OutReady,
  output logic       Busy
);
  localparam int NUM_CH = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t     state, state_nxt;
  logic [3:0] key, key_next;
  logic       pend_key;
  logic       last_gnt;
  logic       id_reg;
  logic [1:0] gnt_d;
  logic [1:0] pick;
  logic       load_key, capture, accept;
  logic [NUM_CH-1:0][3:0] rkey;
  logic [NUM_CH-1:0]      inc;

  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_ch
      assign inc[c] = accept && (OutId == c[0]);
      xor_cipher_chan #(.ROT_EN(ROT_EN)) u_chan (
        .clk  (Clock),
        .rst_n(Resetn),
        .clr  (load_key),
        .inc  (inc[c]),
        .key  (key),
        .rkey (rkey[c])
      );
    end
  endgenerate

  // Round-robin: on a tie the channel that did not win last time goes first.
  always_comb begin
    pick = Req;
    if (Req == 2'b11) pick = last_gnt ? 2'b01 : 2'b10;
  end

  always_comb begin
    state_nxt = state;
    gnt_d     = 2'b00;
    load_key  = 1'b0;
    capture   = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        // A pending key load always beats arbitration and burns the cycle.
        if (pend_key) begin
          load_key = 1'b1;
        end else if (Req != 2'b00) begin
          gnt_d     = pick;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        capture   = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (OutReady) begin
          accept    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pend_key <= 1'b0;
      key_next <= 4'b0000;
      key      <= KEY_RESET;
    end else begin
      if (KeyLoad) begin
        pend_key <= 1'b1;
        key_next <= KeyIn;
      end else if (load_key) begin
        pend_key <= 1'b0;
      end
      if (load_key) key <= key_next;
    end
  end

  // Word/key are latched into the datapath drive registers at grant time so
  // the datapath settles during ISSUE and they hold until the next grant.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Gnt     <= 2'b00;
      XorWord <= 4'b0000;
      XorKey  <= 4'b0000;
      id_reg  <= 1'b0;
    end else begin
      Gnt <= gnt_d;
      if (gnt_d != 2'b00) begin
        XorWord <= gnt_d[1] ? Data1 : Data0;
        XorKey  <= rkey[gnt_d[1]];
        id_reg  <= gnt_d[1];
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      OutValid <= 1'b0;
      OutData  <= 4'b0000;
      OutId    <= 1'b0;
      last_gnt <= 1'b1;
    end else begin
      if (capture) begin
        OutValid <= 1'b1;
        OutData  <= XorOut;
        OutId    <= id_reg;
      end else if (accept) begin
        OutValid <= 1'b0;
        last_gnt <= OutId;
      end
    end
  end

  assign Busy = (state != IDLE);
endmodule

// File: tb/tb_xor_cipher_ctrl.sv
// Directed bench for xor_cipher_ctrl; a rotating instance and a fixed-key instance
// share all inputs, each with its own XOR datapath model.

module tb_xor_cipher_ctrl;
  logic       Clock = 1'b0;
  logic       Resetn;
  logic       KeyLoad;
  logic [3:0] KeyIn;
  logic [1:0] Req;
  logic [3:0] Data0, Data1;
  logic       OutReady;

  logic [1:0] g1, g0;
  logic [3:0] w1, k1, w0, k0, d1, d0;
  logic       v1, v0, id1, id0, b1, b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clock = ~Clock;

  xor_cipher_ctrl #(.ROT_EN(1'b1), .KEY_RESET(4'b0000)) dut_rot (
    .Clock(Clock), .Resetn(Resetn), .KeyLoad(KeyLoad), .KeyIn(KeyIn),
    .Req(Req), .Data0(Data0), .Data1(Data1), .Gnt(g1),
    .XorWord(w1), .XorKey(k1), .XorOut(w1 ^ k1),
    .OutValid(v1), .OutData(d1), .OutId(id1), .OutReady(OutReady), .Busy(b1)
  );

  xor_cipher_ctrl #(.ROT_EN(1'b0), .KEY_RESET(4'b0000)) dut_fix (
    .Clock(Clock), .Resetn(Resetn), .KeyLoad(KeyLoad), .KeyIn(KeyIn),
    .Req(Req), .Data0(Data0), .Data1(Data1), .Gnt(g0),
    .XorWord(w0), .XorKey(k0), .XorOut(w0 ^ k0),
    .OutValid(v0), .OutData(d0), .OutId(id0), .OutReady(OutReady), .Busy(b0)
  );

  initial begin
    #200000;
    $display("FAIL global_timeout got stuck want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic load_key(input logic [3:0] k);
    KeyLoad = 1'b1;
    KeyIn   = k;
    tick();
    KeyLoad = 1'b0;
    tick();
  endtask

  // One full transaction with OutReady high; returns both instances' results.
  task automatic send_word(input int ch, input logic [3:0] data,
                           output logic [3:0] r1, output logic [3:0] r0,
                           output logic rid, output bit to);
    bit got;
    to = 1'b0; r1 = 4'hx; r0 = 4'hx; rid = 1'bx;
    if (ch == 1) Data1 = data; else Data0 = data;
    Req[ch] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (g1[ch]) got = 1'b1;
    end
    Req[ch] = 1'b0;
    if (!got) begin to = 1'b1; return; end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (v1) got = 1'b1;
    end
    if (!got) begin to = 1'b1; return; end
    r1 = d1; r0 = d0; rid = id1;
    tick();
  endtask

  task automatic test_reset();
    logic [3:0] r1, r0; logic rid; bit to;
    Resetn = 1'b0; KeyLoad = 1'b0; KeyIn = 4'h0; Req = 2'b00;
    Data0 = 4'h0; Data1 = 4'h0; OutReady = 1'b0;
    tick(); tick();
    n_vec++; if ({g1, v1, d1, id1, w1, k1, b1} !== 16'h0) begin
      n_err++; $display("FAIL reset_outputs got %h want 0000", {g1, v1, d1, id1, w1, k1, b1});
    end
    Resetn = 1'b1;
    tick();
    // Reach HOLD with backpressure, then reset mid-HOLD.
    Data0 = 4'b0101; Req = 2'b01;
    tick();
    Req = 2'b00;
    n_vec++; if (g1 !== 2'b01 || b1 !== 1'b1) begin
      n_err++; $display("FAIL reset_pre_gnt got gnt=%b busy=%b want 01/1", g1, b1);
    end
    tick(); tick();
    n_vec++; if (v1 !== 1'b1 || d1 !== 4'b0101) begin
      n_err++; $display("FAIL reset_pre_hold got v=%b d=%b want 1/0101", v1, d1);
    end
    Resetn = 1'b0;
    #1;
    n_vec++; if (v1 !== 1'b0 || g1 !== 2'b00 || b1 !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_hold got v=%b g=%b busy=%b want 0/00/0", v1, g1, b1);
    end
    tick();
    Resetn = 1'b1;
    OutReady = 1'b1;
    tick();
    send_word(0, 4'b0101, r1, r0, rid, to);
    n_vec++; if (to || r1 !== 4'b0101 || rid !== 1'b0) begin
      n_err++; $display("FAIL reset_first_word got d=%b id=%b to=%0d want 0101/0/0", r1, rid, to);
    end
  endtask

  task automatic test_key_rotation();
    logic [3:0] r1, r0; logic rid; bit to;
    load_key(4'b1001);
    send_word(0, 4'b0110, r1, r0, rid, to);
    n_vec++; if (to || r1 !== 4'b1111 || rid !== 1'b0) begin
      n_err++; $display("FAIL rot_word0 got d=%b id=%b to=%0d want 1111/0/0", r1, rid, to);
    end
    send_word(0, 4'b0000, r1, r0, rid, to);
    n_vec++; if (to || r1 !== 4'b0011 || rid !== 1'b0) begin
      n_err++; $display("FAIL rot_word1 got d=%b id=%b to=%0d want 0011/0/0", r1, rid, to);
    end
  endtask

  task automatic test_decrypt();
    logic [3:0] r1, r0; logic rid; bit to;
    load_key(4'b1001);
    send_word(0, 4'b0110, r1, r0, rid, to);
    n_vec++; if (to || r1 !== 4'b1111) begin
      n_err++; $display("FAIL dec_ch0 got d=%b to=%0d want 1111", r1, to);
    end
    // ch1 counter is still 0 even though ch0 has advanced.
    send_word(1, 4'b1111, r1, r0, rid, to);
    n_vec++; if (to || r1 !== 4'b0110 || rid !== 1'b1) begin
      n_err++; $display("FAIL dec_ch1_first got d=%b id=%b to=%0d want 0110/1", r1, rid, to);
    end
    send_word(1, 4'b1111, r1, r0, rid, to);
    n_vec++; if (to || r1 !== 4'b1100 || rid !== 1'b1) begin
      n_err++; $display("FAIL dec_ch1_second got d=%b id=%b to=%0d want 1100/1", r1, rid, to);
    end
  endtask

  task automatic test_arbitration();
    logic [1:0] exp;
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
    OutReady = 1'b1; Data0 = 4'h3; Data1 = 4'hc;
    Req = 2'b11;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i % 3 == 1) exp = ((i / 3) % 2 == 1) ? 2'b10 : 2'b01;
      else            exp = 2'b00;
      n_vec++; if (g1 !== exp) begin
        n_err++; $display("FAIL arb_cycle%0d got gnt=%b want %b", i, g1, exp);
      end
    end
    Req = 2'b00;
    tick(); tick();
  endtask

  task automatic test_backpressure();
    OutReady = 1'b0;
    Data0 = 4'b1010; Req = 2'b01;
    tick();
    n_vec++; if (g1 !== 2'b01) begin
      n_err++; $display("FAIL bp_gnt got %b want 01", g1);
    end
    Req = 2'b11;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++; if (v1 !== 1'b1 || d1 !== 4'b1010 || g1 !== 2'b00) begin
        n_err++; $display("FAIL bp_hold%0d got v=%b d=%b g=%b want 1/1010/00", i, v1, d1, g1);
      end
    end
    OutReady = 1'b1;
    tick();
    n_vec++; if (v1 !== 1'b0 || b1 !== 1'b0) begin
      n_err++; $display("FAIL bp_release got v=%b busy=%b want 0/0", v1, b1);
    end
    tick();
    n_vec++; if (g1 !== 2'b10) begin
      n_err++; $display("FAIL bp_next_gnt got %b want 10", g1);
    end
    Req = 2'b00;
    tick(); tick(); tick();
  endtask

  task automatic test_counter_wrap();
    logic [3:0] r1, r0; logic rid; bit to;
    logic [3:0] exp_rot [5];
    exp_rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    load_key(4'b0001);
    for (int i = 0; i < 5; i++) begin
      send_word(0, 4'b0000, r1, r0, rid, to);
      n_vec++; if (to || r1 !== exp_rot[i]) begin
        n_err++; $display("FAIL wrap_rot%0d got %b to=%0d want %b", i, r1, to, exp_rot[i]);
      end
      n_vec++; if (to || r0 !== 4'b0001) begin
        n_err++; $display("FAIL wrap_fixed%0d got %b to=%0d want 0001", i, r0, to);
      end
    end
  endtask

  initial begin
    test_reset();
    test_key_rotation();
    test_decrypt();
    test_arbitration();
    test_backpressure();
    test_counter_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
